// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch-stage redirect logic.
package mips_pkg;

    typedef enum logic [2:0] {
        BOP_NONE = 3'b000,
        BOP_BEQ  = 3'b001,
        BOP_BNE  = 3'b010,
        BOP_BLEZ = 3'b011,
        BOP_BGTZ = 3'b100,
        BOP_BLTZ = 3'b101,
        BOP_BGEZ = 3'b110
    } bop_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10
    } jump_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluator; signed compares of rs against rt or zero.
module br_cond
    import mips_pkg::*;
(
    input  logic [2:0]  bop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        taken
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs[31];
    assign rs_zero = (rs == 32'd0);

    always_comb begin
        taken = 1'b0;
        case (bop)
            BOP_BEQ:  taken = (rs == rt);
            BOP_BNE:  taken = (rs != rt);
            BOP_BLEZ: taken = rs_neg | rs_zero;
            BOP_BGTZ: taken = !rs_neg && !rs_zero;
            BOP_BLTZ: taken = rs_neg;
            BOP_BGEZ: taken = !rs_neg;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_pc_redirect.sv
// Fetch PC register with branch/jump resolution and a one-entry pending
// redirect buffer that holds a taken target across a fetch stall.
//
//   state | meaning
//   RUN   | normal fetch; PC advances or takes redirect when unstalled
//   HOLD  | taken target captured during stall; loads it on release
module if_pc_redirect
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_id_valid,
    input  logic [2:0]  i_con_bop,
    input  logic [1:0]  i_con_jump,
    input  logic [31:0] i_id_pc,
    input  logic [15:0] i_id_imm,
    input  logic [25:0] i_id_jidx,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [31:0] o_pc,
    output logic        o_redirect,
    output logic        o_pending,
    output logic        o_addr_err
);

    pc_state_e   state, state_next;
    logic [31:0] pc_next;
    logic [31:0] pend_target, pend_target_next;
    logic        pend_err, pend_err_next;
    logic        redirect_next, addr_err_next;

    logic        cond_taken, is_j, is_jr, take, jr_err;
    logic [31:0] pc_plus4_id, br_target, j_target, jr_target, target;

    br_cond u_br_cond (
        .bop   (i_con_bop),
        .rs    (i_rs_data),
        .rt    (i_rt_data),
        .taken (cond_taken)
    );

    assign is_j        = (i_con_jump == JMP_J);
    assign is_jr       = (i_con_jump == JMP_JR);
    assign take        = i_id_valid & (is_j | is_jr | cond_taken);
    assign jr_err      = is_jr & (i_rs_data[1:0] != 2'b00);
    assign pc_plus4_id = i_id_pc + 32'd4;
    assign br_target   = pc_plus4_id + {{14{i_id_imm[15]}}, i_id_imm, 2'b00};
    assign j_target    = {pc_plus4_id[31:28], i_id_jidx, 2'b00};
    assign jr_target   = {i_rs_data[31:2], 2'b00};
    assign target      = is_j ? j_target : (is_jr ? jr_target : br_target);

    always_comb begin
        state_next       = state;
        pc_next          = o_pc;
        pend_target_next = pend_target;
        pend_err_next    = pend_err;
        redirect_next    = 1'b0;
        addr_err_next    = 1'b0;
        case (state)
            RUN: begin
                if (!i_stall) begin
                    if (take) begin
                        pc_next       = target;
                        redirect_next = 1'b1;
                        addr_err_next = jr_err;
                    end else begin
                        pc_next = o_pc + 32'd4;
                    end
                end else if (take) begin
                    pend_target_next = target;
                    pend_err_next    = jr_err;
                    state_next       = HOLD;
                end
            end
            HOLD: begin
                // ID inputs are ignored here: the stalled instruction is the
                // one already captured, and the pending target always wins.
                if (!i_stall) begin
                    pc_next       = pend_target;
                    redirect_next = 1'b1;
                    addr_err_next = pend_err;
                    state_next    = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= RUN;
            o_pc        <= RESET_PC;
            pend_target <= 32'd0;
            pend_err    <= 1'b0;
            o_redirect  <= 1'b0;
            o_addr_err  <= 1'b0;
        end else begin
            state       <= state_next;
            o_pc        <= pc_next;
            pend_target <= pend_target_next;
            pend_err    <= pend_err_next;
            o_redirect  <= redirect_next;
            o_addr_err  <= addr_err_next;
        end
    end

    assign o_pending = (state == HOLD);

endmodule

// File: tb/tb_if_pc_redirect.sv
// Directed bench for if_pc_redirect: vector table plus stall/reset sequences.
module tb_if_pc_redirect;

    logic        clk = 1'b0;
    logic        rst_n, stall, id_valid;
    logic [2:0]  con_bop;
    logic [1:0]  con_jump;
    logic [31:0] id_pc, rs_data, rt_data;
    logic [15:0] id_imm;
    logic [25:0] id_jidx;
    logic [31:0] pc;
    logic        redirect, pending, addr_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    if_pc_redirect dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_stall    (stall),
        .i_id_valid (id_valid),
        .i_con_bop  (con_bop),
        .i_con_jump (con_jump),
        .i_id_pc    (id_pc),
        .i_id_imm   (id_imm),
        .i_id_jidx  (id_jidx),
        .i_rs_data  (rs_data),
        .i_rt_data  (rt_data),
        .o_pc       (pc),
        .o_redirect (redirect),
        .o_pending  (pending),
        .o_addr_err (addr_err)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  bop;
        logic [1:0]  jump;
        logic [31:0] ipc;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        taken;
        logic [31:0] target;
        logic        err;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] b, input logic [1:0] j,
                         input logic [31:0] ipc, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] rs, input logic [31:0] rt);
        id_valid = v; con_bop = b; con_jump = j; id_pc = ipc;
        id_imm = imm; id_jidx = jidx; rs_data = rs; rt_data = rt;
    endtask

    initial begin
        //          valid bop   jump  ipc            imm       jidx        rs             rt     tk   target         err
        vecs[0]  = '{1'b1, 3'd1, 2'd0, 32'h100,       16'h0003, 26'h0,      32'd5,         32'd5, 1'b1, 32'h110,       1'b0};
        vecs[1]  = '{1'b1, 3'd2, 2'd0, 32'h100,       16'h0003, 26'h0,      32'd5,         32'd5, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 3'd3, 2'd0, 32'h100,       16'hFFFF, 26'h0,      32'h8000_0000, 32'd0, 1'b1, 32'h100,       1'b0};
        vecs[3]  = '{1'b1, 3'd3, 2'd0, 32'h100,       16'hFFFF, 26'h0,      32'd0,         32'd0, 1'b1, 32'h100,       1'b0};
        vecs[4]  = '{1'b1, 3'd3, 2'd0, 32'h100,       16'hFFFF, 26'h0,      32'd1,         32'd0, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 3'd4, 2'd0, 32'h200,       16'h0010, 26'h0,      32'h8000_0000, 32'd0, 1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 3'd4, 2'd0, 32'h200,       16'h0010, 26'h0,      32'd0,         32'd0, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 3'd4, 2'd0, 32'h200,       16'h0010, 26'h0,      32'd1,         32'd0, 1'b1, 32'h244,       1'b0};
        vecs[8]  = '{1'b1, 3'd5, 2'd0, 32'h200,       16'h0001, 26'h0,      32'h8000_0000, 32'd0, 1'b1, 32'h208,       1'b0};
        vecs[9]  = '{1'b1, 3'd5, 2'd0, 32'h200,       16'h0001, 26'h0,      32'd0,         32'd0, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 3'd5, 2'd0, 32'h200,       16'h0001, 26'h0,      32'd1,         32'd0, 1'b0, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 3'd6, 2'd0, 32'h300,       16'h0002, 26'h0,      32'h8000_0000, 32'd0, 1'b0, 32'h0,         1'b0};
        vecs[12] = '{1'b1, 3'd6, 2'd0, 32'h300,       16'h0002, 26'h0,      32'd0,         32'd0, 1'b1, 32'h30C,       1'b0};
        vecs[13] = '{1'b1, 3'd6, 2'd0, 32'h300,       16'hFFFE, 26'h0,      32'd1,         32'd0, 1'b1, 32'h2FC,       1'b0};
        vecs[14] = '{1'b1, 3'd0, 2'd1, 32'h3000_0000, 16'h0,    26'h000_0040, 32'd0,       32'd0, 1'b1, 32'h3000_0100, 1'b0};
        vecs[15] = '{1'b1, 3'd0, 2'd2, 32'h0,         16'h0,    26'h0,      32'h2003,      32'd0, 1'b1, 32'h2000,      1'b1};
        vecs[16] = '{1'b1, 3'd0, 2'd2, 32'h0,         16'h0,    26'h0,      32'h4000,      32'd0, 1'b1, 32'h4000,      1'b0};
        vecs[17] = '{1'b1, 3'd7, 2'd0, 32'h100,       16'h0003, 26'h0,      32'd9,         32'd9, 1'b0, 32'h0,         1'b0};
        vecs[18] = '{1'b0, 3'd1, 2'd0, 32'h100,       16'h0003, 26'h0,      32'd9,         32'd9, 1'b0, 32'h0,         1'b0};
        vecs[19] = '{1'b1, 3'd0, 2'd3, 32'h100,       16'h0003, 26'h123,    32'd8,         32'd0, 1'b0, 32'h0,         1'b0};
        vecs[20] = '{1'b1, 3'd2, 2'd1, 32'h1000_0000, 16'h0003, 26'h100,    32'd1,         32'd2, 1'b1, 32'h1000_0400, 1'b0};
        vecs[21] = '{1'b1, 3'd0, 2'd2, 32'h0,         16'h0,    26'h0,      32'hFFFF_FFFC, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[22] = '{1'b0, 3'd0, 2'd0, 32'h0,         16'h0,    26'h0,      32'd0,         32'd0, 1'b0, 32'h0,         1'b0};

        // reset while stalled
        rst_n = 1'b0; stall = 1'b1;
        drive(1'b1, 3'd1, 2'd0, 32'h100, 16'h3, 26'h0, 32'd5, 32'd5);
        tick(); tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_pending", {31'd0, pending}, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_addr_err", {31'd0, addr_err}, 32'd0);

        rst_n = 1'b1; stall = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 32'h0, 16'h0, 26'h0, 32'd0, 32'd0);
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            chk("idle_pc", pc, exp_pc);
        end

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].valid, vecs[i].bop, vecs[i].jump, vecs[i].ipc,
                  vecs[i].imm, vecs[i].jidx, vecs[i].rs, vecs[i].rt);
            tick();
            exp_pc = vecs[i].taken ? vecs[i].target : exp_pc + 32'd4;
            chk($sformatf("vec%0d_pc", i), pc, exp_pc);
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].taken});
            chk($sformatf("vec%0d_addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].err});
        end

        // stalled, not taken: pc holds, no pending
        stall = 1'b1;
        drive(1'b1, 3'd2, 2'd0, 32'h500, 16'h4, 26'h0, 32'd7, 32'd7);
        tick();
        chk("stall_nt_pc", pc, exp_pc);
        chk("stall_nt_pending", {31'd0, pending}, 32'd0);

        // stalled taken beq -> HOLD, operands change while held
        drive(1'b1, 3'd1, 2'd0, 32'h500, 16'h4, 26'h0, 32'd7, 32'd7);
        tick();
        chk("hold_pending", {31'd0, pending}, 32'd1);
        chk("hold_pc0", pc, exp_pc);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd0, 2'd2, 32'h700 + i, 16'h8, 26'h0, 32'h9000 + 32'(i * 4), 32'd1);
            tick();
            chk("hold_pc", pc, exp_pc);
            chk("hold_pending_n", {31'd0, pending}, 32'd1);
            chk("hold_redirect", {31'd0, redirect}, 32'd0);
        end

        // release with a competing taken jump; pending target must win
        stall = 1'b0;
        drive(1'b1, 3'd0, 2'd1, 32'h0, 16'h0, 26'h3FF, 32'd0, 32'd0);
        tick();
        exp_pc = 32'h514;
        chk("release_pc", pc, exp_pc);
        chk("release_redirect", {31'd0, redirect}, 32'd1);
        chk("release_pending", {31'd0, pending}, 32'd0);
        drive(1'b0, 3'd0, 2'd0, 32'h0, 16'h0, 26'h0, 32'd0, 32'd0);
        tick();
        exp_pc = exp_pc + 32'd4;
        chk("after_release_pc", pc, exp_pc);
        chk("after_release_redirect", {31'd0, redirect}, 32'd0);

        // stalled misaligned jr: error reported when the held target loads
        stall = 1'b1;
        drive(1'b1, 3'd0, 2'd2, 32'h0, 16'h0, 26'h0, 32'h6001, 32'd0);
        tick();
        chk("jr_hold_err", {31'd0, addr_err}, 32'd0);
        stall = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 32'h0, 16'h0, 26'h0, 32'd0, 32'd0);
        tick();
        chk("jr_release_pc", pc, 32'h6000);
        chk("jr_release_err", {31'd0, addr_err}, 32'd1);

        // reset during HOLD discards the pending target
        stall = 1'b1;
        drive(1'b1, 3'd1, 2'd0, 32'h800, 16'h4, 26'h0, 32'd3, 32'd3);
        tick();
        chk("hold2_pending", {31'd0, pending}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("hold_reset_pc", pc, 32'h0);
        chk("hold_reset_pending", {31'd0, pending}, 32'd0);
        chk("hold_reset_redirect", {31'd0, redirect}, 32'd0);
        rst_n = 1'b1; stall = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 32'h0, 16'h0, 26'h0, 32'd0, 32'd0);
        tick();
        chk("post_reset_pc", pc, 32'h4);
        chk("post_reset_redirect", {31'd0, redirect}, 32'd0);
        chk("post_reset_pending", {31'd0, pending}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
